// File: rtl/pipe_pkg.sv
// Shared definitions for the integer pipeline control path.
//   STALL_* : 2-bit stall codes understood by every pipeline register
//             (IF/ID, ID/EX, EX/MEM, MEM/WB).
//   div_st_t: occupancy state of the multi-cycle divider in EX.
package pipe_pkg;

  localparam logic [1:0] STALL_RUN    = 2'b00;  // load the input
  localparam logic [1:0] STALL_FLUSH  = 2'b01;  // clear to zero
  localparam logic [1:0] STALL_BUBBLE = 2'b10;  // clear to zero
  localparam logic [1:0] STALL_HOLD   = 2'b11;  // keep current value

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } div_st_t;

endpackage

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush controller for the 5-stage integer pipeline.
// Arbitrates data-memory wait, multi-cycle divide, branch/exception flush
// and load-use hazards, and drives the PC hold plus the stall code of each
// pipeline register. A flush raised while a higher-priority hold is active
// is latched and applied once the hold releases.
//
// Ports:
//   clk            clock
//   rst            synchronous reset, active-low
//   dmem_wait_i    MEM stage: data memory not ready
//   div_start_i    EX stage holds a divide (level)
//   load_use_i     ID stage: load-use hazard
//   flush_i        EX stage: mispredict/exception pulse
//   stall_pc_o     1 = hold PC
//   stall_ifid_o   stall code, IF/ID
//   stall_idex_o   stall code, ID/EX
//   stall_exmem_o  stall code, EX/MEM
//   stall_memwb_o  stall code, MEM/WB
//   div_busy_o     divide counter active
//   div_last_o     final divide cycle, EX result advances
module pipe_stall_ctrl
  import pipe_pkg::*;
#(
  parameter int DIV_CYCLES = 8,
  parameter int CNT_W      = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dmem_wait_i,
  input  logic       div_start_i,
  input  logic       load_use_i,
  input  logic       flush_i,
  output logic       stall_pc_o,
  output logic [1:0] stall_ifid_o,
  output logic [1:0] stall_idex_o,
  output logic [1:0] stall_exmem_o,
  output logic [1:0] stall_memwb_o,
  output logic       div_busy_o,
  output logic       div_last_o
);

  // The issue cycle and the final (result) cycle are both spent in EX,
  // so the counter covers the cycles in between.
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 2);

  div_st_t          div_st_reg,     div_st_next;
  logic [CNT_W-1:0] div_cnt_reg,    div_cnt_next;
  logic             flush_pend_reg, flush_pend_next;

  logic cnt_zero;
  logic div_stall;
  logic div_last;
  logic apply_flush;

  assign cnt_zero    = (div_cnt_reg == '0);
  assign div_stall   = ((div_st_reg == IDLE) && div_start_i) ||
                       ((div_st_reg == BUSY) && !cnt_zero);
  assign div_last    = (div_st_reg == BUSY) && cnt_zero;
  assign apply_flush = !dmem_wait_i && !div_stall && (flush_i || flush_pend_reg);

  // Next-state logic
  always_comb begin
    div_st_next     = div_st_reg;
    div_cnt_next    = div_cnt_reg;
    flush_pend_next = flush_pend_reg;

    case (div_st_reg)
      IDLE: begin
        // A divide is only issued once memory lets the pipe move.
        if (div_start_i && !dmem_wait_i) begin
          div_st_next  = BUSY;
          div_cnt_next = DIV_LOAD;
        end
      end
      BUSY: begin
        if (!cnt_zero) begin
          // The divider keeps computing even while memory stalls the pipe.
          div_cnt_next = div_cnt_reg - 1'b1;
        end else if (!dmem_wait_i) begin
          div_st_next = IDLE;
        end
      end
      default: div_st_next = IDLE;
    endcase

    if (apply_flush) begin
      flush_pend_next = 1'b0;
    end else if (flush_i && (dmem_wait_i || div_stall)) begin
      flush_pend_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_st_reg     <= IDLE;
      div_cnt_reg    <= '0;
      flush_pend_reg <= 1'b0;
    end else begin
      div_st_reg     <= div_st_next;
      div_cnt_reg    <= div_cnt_next;
      flush_pend_reg <= flush_pend_next;
    end
  end

  // Priority output mux: dmem wait > divide > flush > load-use > run.
  always_comb begin
    stall_pc_o    = 1'b0;
    stall_ifid_o  = STALL_RUN;
    stall_idex_o  = STALL_RUN;
    stall_exmem_o = STALL_RUN;
    stall_memwb_o = STALL_RUN;
    div_busy_o    = (div_st_reg == BUSY);
    div_last_o    = div_last;

    if (!rst) begin
      stall_pc_o    = 1'b1;
      stall_ifid_o  = STALL_FLUSH;
      stall_idex_o  = STALL_FLUSH;
      stall_exmem_o = STALL_FLUSH;
      stall_memwb_o = STALL_FLUSH;
      div_busy_o    = 1'b0;
      div_last_o    = 1'b0;
    end else if (dmem_wait_i) begin
      stall_pc_o    = 1'b1;
      stall_ifid_o  = STALL_HOLD;
      stall_idex_o  = STALL_HOLD;
      stall_exmem_o = STALL_HOLD;
      stall_memwb_o = STALL_BUBBLE;
    end else if (div_stall) begin
      stall_pc_o    = 1'b1;
      stall_ifid_o  = STALL_HOLD;
      stall_idex_o  = STALL_HOLD;
      stall_exmem_o = STALL_BUBBLE;
    end else if (flush_i || flush_pend_reg) begin
      stall_ifid_o  = STALL_FLUSH;
      stall_idex_o  = STALL_FLUSH;
    end else if (load_use_i) begin
      stall_pc_o    = 1'b1;
      stall_ifid_o  = STALL_HOLD;
      stall_idex_o  = STALL_BUBBLE;
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
module tb_pipe_stall_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic dmem_wait_i = 1'b0;
  logic div_start_i = 1'b0;
  logic load_use_i  = 1'b0;
  logic flush_i     = 1'b0;

  logic       pc8, busy8, last8, pc4, busy4, last4;
  logic [1:0] ifid8, idex8, exmem8, memwb8;
  logic [1:0] ifid4, idex4, exmem4, memwb4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.DIV_CYCLES(8), .CNT_W(6)) dut8 (
    .clk(clk), .rst(rst),
    .dmem_wait_i(dmem_wait_i), .div_start_i(div_start_i),
    .load_use_i(load_use_i), .flush_i(flush_i),
    .stall_pc_o(pc8), .stall_ifid_o(ifid8), .stall_idex_o(idex8),
    .stall_exmem_o(exmem8), .stall_memwb_o(memwb8),
    .div_busy_o(busy8), .div_last_o(last8)
  );

  pipe_stall_ctrl #(.DIV_CYCLES(4), .CNT_W(6)) dut4 (
    .clk(clk), .rst(rst),
    .dmem_wait_i(dmem_wait_i), .div_start_i(div_start_i),
    .load_use_i(load_use_i), .flush_i(flush_i),
    .stall_pc_o(pc4), .stall_ifid_o(ifid4), .stall_idex_o(idex4),
    .stall_exmem_o(exmem4), .stall_memwb_o(memwb4),
    .div_busy_o(busy4), .div_last_o(last4)
  );

  // Observation vector: {pc, ifid, idex, exmem, memwb, busy, last}
  wire [10:0] obs8 = {pc8, ifid8, idex8, exmem8, memwb8, busy8, last8};
  wire [10:0] obs4 = {pc4, ifid4, idex4, exmem4, memwb4, busy4, last4};

  function automatic logic [10:0] ev(input logic pc, input logic [1:0] a,
                                     input logic [1:0] b, input logic [1:0] c,
                                     input logic [1:0] d, input logic busy,
                                     input logic last);
    return {pc, a, b, c, d, busy, last};
  endfunction

  // Inputs change on the falling edge; outputs are sampled 1 time unit later,
  // well away from the rising edge.
  task automatic drive(input logic dw, input logic ds, input logic lu, input logic fl);
    @(negedge clk);
    dmem_wait_i = dw;
    div_start_i = ds;
    load_use_i  = lu;
    flush_i     = fl;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    dmem_wait_i = 0; div_start_i = 0; load_use_i = 0; flush_i = 0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [10:0] exp;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive(1, 1, 1, 1);
      exp = ev(1, 2'b01, 2'b01, 2'b01, 2'b01, 0, 0);
      total++;
      $display("reset c%0d obs8=%b exp=%b", c, obs8, exp);
      if (obs8 !== exp) begin
        bad++;
        $display("FAIL reset_hold c%0d got=%b want=%b", c, obs8, exp);
      end
      total++;
      if (obs4 !== exp) begin
        bad++;
        $display("FAIL reset_hold4 c%0d got=%b want=%b", c, obs4, exp);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    dmem_wait_i = 0; div_start_i = 0; load_use_i = 0; flush_i = 0;
    #1;
    exp = ev(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
    total++;
    $display("release obs8=%b exp=%b", obs8, exp);
    if (obs8 !== exp) begin
      bad++;
      $display("FAIL reset_release got=%b want=%b", obs8, exp);
    end
  endtask

  task automatic test_divide();
    logic [10:0] exp;
    do_reset();
    for (int c = 0; c <= 8; c++) begin
      drive(0, (c <= 7), 0, 0);
      if (c == 0)      exp = ev(1, 2'b11, 2'b11, 2'b10, 2'b00, 0, 0);
      else if (c <= 6) exp = ev(1, 2'b11, 2'b11, 2'b10, 2'b00, 1, 0);
      else if (c == 7) exp = ev(0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 1);
      else             exp = ev(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
      total++;
      $display("divide8 c%0d obs=%b exp=%b", c, obs8, exp);
      if (obs8 !== exp) begin
        bad++;
        $display("FAIL divide8 c%0d got=%b want=%b", c, obs8, exp);
      end
    end
  endtask

  task automatic test_load_use();
    logic [10:0] exp;
    do_reset();
    drive(0, 0, 1, 0);
    exp = ev(1, 2'b11, 2'b10, 2'b00, 2'b00, 0, 0);
    total++;
    $display("load_use obs=%b exp=%b", obs8, exp);
    if (obs8 !== exp) begin
      bad++;
      $display("FAIL load_use got=%b want=%b", obs8, exp);
    end
    drive(0, 0, 0, 0);
    exp = ev(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
    total++;
    $display("load_use_after obs=%b exp=%b", obs8, exp);
    if (obs8 !== exp) begin
      bad++;
      $display("FAIL load_use_after got=%b want=%b", obs8, exp);
    end
  endtask

  task automatic test_dmem_over_div_end();
    logic [10:0] exp;
    do_reset();
    for (int c = 0; c <= 7; c++) begin
      drive((c >= 2 && c <= 5), (c <= 6), 0, 0);
      case (c)
        0:       exp = ev(1, 2'b11, 2'b11, 2'b10, 2'b00, 0, 0);
        1:       exp = ev(1, 2'b11, 2'b11, 2'b10, 2'b00, 1, 0);
        2:       exp = ev(1, 2'b11, 2'b11, 2'b11, 2'b10, 1, 0);
        3, 4, 5: exp = ev(1, 2'b11, 2'b11, 2'b11, 2'b10, 1, 1);
        6:       exp = ev(0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 1);
        default: exp = ev(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
      endcase
      total++;
      $display("dmem_div4 c%0d obs=%b exp=%b", c, obs4, exp);
      if (obs4 !== exp) begin
        bad++;
        $display("FAIL dmem_div4 c%0d got=%b want=%b", c, obs4, exp);
      end
    end
  endtask

  task automatic test_deferred_flush();
    logic [10:0] exp;
    do_reset();
    for (int c = 0; c <= 5; c++) begin
      drive((c <= 3), 0, (c == 4), (c == 1));
      if (c <= 3)      exp = ev(1, 2'b11, 2'b11, 2'b11, 2'b10, 0, 0);
      else if (c == 4) exp = ev(0, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0);
      else             exp = ev(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
      total++;
      $display("deferred_flush c%0d obs=%b exp=%b", c, obs8, exp);
      if (obs8 !== exp) begin
        bad++;
        $display("FAIL deferred_flush c%0d got=%b want=%b", c, obs8, exp);
      end
    end
  endtask

  // Flush raised during a divide stall is held until the divide result cycle.
  task automatic test_flush_during_div();
    logic [10:0] exp;
    do_reset();
    for (int c = 0; c <= 4; c++) begin
      drive(0, (c <= 3), 0, (c == 1));
      if (c <= 2)      exp = ev(1, 2'b11, 2'b11, 2'b10, 2'b00, (c != 0), 0);
      else if (c == 3) exp = ev(0, 2'b01, 2'b01, 2'b00, 2'b00, 1, 1);
      else             exp = ev(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
      total++;
      $display("flush_div4 c%0d obs=%b exp=%b", c, obs4, exp);
      if (obs4 !== exp) begin
        bad++;
        $display("FAIL flush_div4 c%0d got=%b want=%b", c, obs4, exp);
      end
    end
  endtask

  task automatic test_flush_vs_load_use();
    logic [10:0] exp;
    do_reset();
    drive(0, 0, 1, 1);
    exp = ev(0, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0);
    total++;
    $display("flush_vs_lu obs=%b exp=%b", obs8, exp);
    if (obs8 !== exp) begin
      bad++;
      $display("FAIL flush_vs_lu got=%b want=%b", obs8, exp);
    end
    drive(0, 0, 0, 0);
    exp = ev(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
    total++;
    $display("flush_vs_lu_after obs=%b exp=%b", obs8, exp);
    if (obs8 !== exp) begin
      bad++;
      $display("FAIL flush_vs_lu_after got=%b want=%b", obs8, exp);
    end
  endtask

  initial begin
    test_reset();
    test_divide();
    test_load_use();
    test_dmem_over_div_end();
    test_deferred_flush();
    test_flush_during_div();
    test_flush_vs_load_use();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
